// File: rtl/axi_struct_pkg.sv
// AXI4 channel bundles for a single 32-bit write port and read port.
package axi_struct_pkg;

    localparam int AXI_AW = 32;
    localparam int AXI_DW = 32;
    localparam int AXI_IW = 4;

    typedef struct packed {
        logic [AXI_IW-1:0]   awid;
        logic [AXI_AW-1:0]   awaddr;
        logic [7:0]          awlen;
        logic [2:0]          awsize;
        logic [1:0]          awburst;
        logic                awvalid;
        logic [AXI_DW-1:0]   wdata;
        logic [AXI_DW/8-1:0] wstrb;
        logic                wlast;
        logic                wvalid;
        logic                bready;
    } axi_wr_req_t;

    typedef struct packed {
        logic              awready;
        logic              wready;
        logic [AXI_IW-1:0] bid;
        logic [1:0]        bresp;
        logic              bvalid;
    } axi_wr_rsp_t;

    typedef struct packed {
        logic [AXI_IW-1:0] arid;
        logic [AXI_AW-1:0] araddr;
        logic [7:0]        arlen;
        logic [2:0]        arsize;
        logic [1:0]        arburst;
        logic              arvalid;
        logic              rready;
    } axi_rd_req_t;

    typedef struct packed {
        logic              arready;
        logic [AXI_IW-1:0] rid;
        logic [AXI_DW-1:0] rdata;
        logic [1:0]        rresp;
        logic              rlast;
        logic              rvalid;
    } axi_rd_rsp_t;

endpackage

// File: rtl/tlul_axi_bridge_pkg.sv
// Bridge FSM states and AXI response/burst encodings.
// DRAIN exists only when TLUL_AXI_BRIDGE_TIMEOUT_EN is defined.
package tlul_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_RESP = 3'd4,
`ifdef TLUL_AXI_BRIDGE_TIMEOUT_EN
        TL_RSP  = 3'd5,
        DRAIN   = 3'd6
`else
        TL_RSP  = 3'd5
`endif
    } state_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    localparam logic [1:0] INCR = 2'b01;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == SLVERR) || (resp == DECERR);
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type and opcode definitions shared by the bridge and its host.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_AUW = 7;
    localparam int TL_DUW = 7;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    localparam logic [TL_DUW-1:0] TL_D_USER_DEFAULT = '0;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_AUW-1:0] a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_axi_bridge_ctrl.sv
// Single-outstanding TL-UL to AXI4 bridge: one TL request becomes one single-beat AXI access.
// Define TLUL_AXI_BRIDGE_TIMEOUT_EN to bound the B/R wait and drain late beats afterwards.
module tlul_axi_bridge_ctrl
    import tlul_pkg::*;
    import axi_struct_pkg::*;
    import tlul_axi_bridge_pkg::*;
#(
    parameter int AddrW         = 32,
    parameter int TimeoutCycles = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  tlul_pkg::tl_h2d_t           tl_i,
    output tlul_pkg::tl_d2h_t           tl_o,
    output axi_struct_pkg::axi_wr_req_t axi_wr_req_o,
    input  axi_struct_pkg::axi_wr_rsp_t axi_wr_rsp_i,
    output axi_struct_pkg::axi_rd_req_t axi_rd_req_o,
    input  axi_struct_pkg::axi_rd_rsp_t axi_rd_rsp_i
);

    localparam logic [AXI_AW-1:0] AddrMask = AXI_AW'((64'd1 << AddrW) - 64'd1);

    state_e state, state_nxt;

    logic              init_done;
    logic [2:0]        cap_op;
    logic [AXI_AW-1:0] cap_addr;
    logic [TL_SZW-1:0] cap_size;
    logic [TL_DBW-1:0] cap_mask;
    logic [TL_DW-1:0]  cap_wdata;
    logic [TL_AIW-1:0] cap_source;
    logic [TL_DW-1:0]  rsp_data;
    logic              rsp_err;
    logic              aw_done;
    logic              w_done;

    logic a_ready, accept, op_write, op_read, cap_read;
    logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic aw_hs, w_hs, ar_hs, b_beat, r_beat;
    logic unused_inputs;

    assign a_ready  = (state == IDLE) && init_done;
    assign accept   = tl_i.a_valid && a_ready;
    assign op_write = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    assign op_read  = (tl_i.a_opcode == Get);
    assign cap_read = (cap_op == Get);

    assign aw_valid = (state == WR_ADDR) && !aw_done;
    assign w_valid  = (state == WR_ADDR) && !w_done;
    assign ar_valid = (state == RD_ADDR);

`ifdef TLUL_AXI_BRIDGE_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] tmo_cnt;
    logic            timed_out;
    logic            tmo_hit;

    // After a timeout the abandoned channel stays ready so the late beat cannot wedge the slave.
    assign b_ready = (state == WR_RESP) || ((state == DRAIN) && !cap_read);
    assign r_ready = (state == RD_RESP) || ((state == DRAIN) && cap_read);
    assign tmo_hit = ((state == WR_RESP) || (state == RD_RESP))
                     && (tmo_cnt == CntW'(TimeoutCycles - 1));
`else
    localparam int unused_timeout_cycles = TimeoutCycles;

    assign b_ready = (state == WR_RESP);
    assign r_ready = (state == RD_RESP);
`endif

    assign aw_hs  = aw_valid && axi_wr_rsp_i.awready;
    assign w_hs   = w_valid && axi_wr_rsp_i.wready;
    assign ar_hs  = ar_valid && axi_rd_rsp_i.arready;
    assign b_beat = b_ready && axi_wr_rsp_i.bvalid;
    assign r_beat = r_ready && axi_rd_rsp_i.rvalid;

    assign unused_inputs = ^{tl_i.a_param, tl_i.a_user, axi_wr_rsp_i.bid,
                             axi_rd_rsp_i.rid, axi_rd_rsp_i.rlast};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (op_write) begin
                        state_nxt = WR_ADDR;
                    end else if (op_read) begin
                        state_nxt = RD_ADDR;
                    end else begin
                        state_nxt = TL_RSP;
                    end
                end
            end
            // AW and W complete independently; either may finish first or both together.
            WR_ADDR: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_beat) begin
                    state_nxt = TL_RSP;
                end
`ifdef TLUL_AXI_BRIDGE_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = TL_RSP;
                end
`endif
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_beat) begin
                    state_nxt = TL_RSP;
                end
`ifdef TLUL_AXI_BRIDGE_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = TL_RSP;
                end
`endif
            end
            TL_RSP: begin
                if (tl_i.d_ready) begin
`ifdef TLUL_AXI_BRIDGE_TIMEOUT_EN
                    state_nxt = timed_out ? DRAIN : IDLE;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef TLUL_AXI_BRIDGE_TIMEOUT_EN
            DRAIN: begin
                if (b_beat || r_beat) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_done  <= 1'b0;
            cap_op     <= '0;
            cap_addr   <= '0;
            cap_size   <= '0;
            cap_mask   <= '0;
            cap_wdata  <= '0;
            cap_source <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (accept) begin
                cap_op     <= tl_i.a_opcode;
                cap_addr   <= tl_i.a_address & AddrMask;
                cap_size   <= tl_i.a_size;
                cap_mask   <= tl_i.a_mask;
                cap_wdata  <= tl_i.a_data;
                cap_source <= tl_i.a_source;
                rsp_data   <= '0;
                rsp_err    <= !(op_write || op_read);
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done <= 1'b1;
            end
            if ((state == WR_RESP) && b_beat) begin
                rsp_err <= resp_is_err(axi_wr_rsp_i.bresp);
            end
            if ((state == RD_RESP) && r_beat) begin
                rsp_data <= axi_rd_rsp_i.rdata;
                rsp_err  <= resp_is_err(axi_rd_rsp_i.rresp);
            end
`ifdef TLUL_AXI_BRIDGE_TIMEOUT_EN
            if (tmo_hit && !b_beat && !r_beat) begin
                rsp_data <= '1;
                rsp_err  <= 1'b1;
            end
`endif
        end
    end

`ifdef TLUL_AXI_BRIDGE_TIMEOUT_EN
    // Counter restarts on every entry because it is held at zero outside the response states.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt   <= '0;
            timed_out <= 1'b0;
        end else begin
            if ((state == WR_RESP) || (state == RD_RESP)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (accept) begin
                timed_out <= 1'b0;
            end else if (tmo_hit && !b_beat && !r_beat) begin
                timed_out <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = (state == TL_RSP);
        tl_o.d_opcode = cap_read ? AccessAckData : AccessAck;
        tl_o.d_param  = '0;
        tl_o.d_size   = cap_size;
        tl_o.d_source = cap_source;
        tl_o.d_sink   = '0;
        tl_o.d_data   = rsp_data;
        tl_o.d_user   = TL_D_USER_DEFAULT;
        tl_o.d_error  = rsp_err;
    end

    always_comb begin
        axi_wr_req_o         = '0;
        axi_wr_req_o.awid    = '0;
        axi_wr_req_o.awaddr  = cap_addr;
        axi_wr_req_o.awlen   = 8'd0;
        axi_wr_req_o.awsize  = {1'b0, cap_size};
        axi_wr_req_o.awburst = INCR;
        axi_wr_req_o.awvalid = aw_valid;
        axi_wr_req_o.wdata   = cap_wdata;
        axi_wr_req_o.wstrb   = cap_mask;
        axi_wr_req_o.wlast   = 1'b1;
        axi_wr_req_o.wvalid  = w_valid;
        axi_wr_req_o.bready  = b_ready;
    end

    always_comb begin
        axi_rd_req_o         = '0;
        axi_rd_req_o.arid    = '0;
        axi_rd_req_o.araddr  = cap_addr;
        axi_rd_req_o.arlen   = 8'd0;
        axi_rd_req_o.arsize  = {1'b0, cap_size};
        axi_rd_req_o.arburst = INCR;
        axi_rd_req_o.arvalid = ar_valid;
        axi_rd_req_o.rready  = r_ready;
    end

endmodule

// File: tb/tb_tlul_axi_bridge_ctrl.sv
// Directed bench for tlul_axi_bridge_ctrl: bench-driven AXI slave, response scoreboard.
// The timeout/drain step runs only when TLUL_AXI_BRIDGE_TIMEOUT_EN is defined.
module tb_tlul_axi_bridge_ctrl;
    import tlul_pkg::*;
    import axi_struct_pkg::*;
    import tlul_axi_bridge_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic        err;
        logic [31:0] data;
        logic [7:0]  src;
        logic [1:0]  size;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    tl_h2d_t     tl_h2d;
    tl_d2h_t     tl_d2h;
    axi_wr_req_t wr_req;
    axi_wr_rsp_t wr_rsp;
    axi_rd_req_t rd_req;
    axi_rd_rsp_t rd_rsp;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    exp_t sb[$];

    tlul_axi_bridge_ctrl #(
        .AddrW        (32),
        .TimeoutCycles(16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tl_i        (tl_h2d),
        .tl_o        (tl_d2h),
        .axi_wr_req_o(wr_req),
        .axi_wr_rsp_i(wr_rsp),
        .axi_rd_req_o(rd_req),
        .axi_rd_rsp_i(rd_rsp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] op, input logic err, input logic [31:0] data,
                            input logic [7:0] src, input logic [1:0] size);
        exp_t e;
        e.op = op; e.err = err; e.data = data; e.src = src; e.size = size;
        sb.push_back(e);
    endtask

    task automatic send_a(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                          input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
        chk("a_ready_idle", 32'(tl_d2h.a_ready), 32'd1);
        tl_h2d.a_valid   = 1'b1;
        tl_h2d.a_opcode  = op;
        tl_h2d.a_address = addr;
        tl_h2d.a_size    = size;
        tl_h2d.a_mask    = mask;
        tl_h2d.a_data    = data;
        tl_h2d.a_source  = src;
        acc_cyc = cyc;
        step();
        tl_h2d.a_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input int exp_lat);
        exp_t e;
        int   waited = 0;
        while (!tl_d2h.d_valid && waited < 64) begin
            step();
            waited++;
        end
        chk({tag, "_d_valid"}, 32'(tl_d2h.d_valid), 32'd1);
        if (!tl_d2h.d_valid) return;
        if (exp_lat > 0) chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
        chk({tag, "_sb_has_entry"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_d_opcode"}, 32'(tl_d2h.d_opcode), 32'(e.op));
        chk({tag, "_d_error"},  32'(tl_d2h.d_error), 32'(e.err));
        chk({tag, "_d_data"},   tl_d2h.d_data, e.data);
        chk({tag, "_d_source"}, 32'(tl_d2h.d_source), 32'(e.src));
        chk({tag, "_d_size"},   32'(tl_d2h.d_size), 32'(e.size));
        chk({tag, "_d_param_sink_user"},
            32'({tl_d2h.d_param, tl_d2h.d_sink, tl_d2h.d_user}), 32'({3'd0, 1'b0, TL_D_USER_DEFAULT}));
        chk({tag, "_a_ready_busy"}, 32'(tl_d2h.a_ready), 32'd0);
        tl_h2d.d_ready = 1'b1;
        step();
        tl_h2d.d_ready = 1'b0;
        chk({tag, "_d_valid_drop"}, 32'(tl_d2h.d_valid), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        tl_h2d = '0;
        wr_rsp = '0;
        rd_rsp = '0;

        // Reset values
        #1;
        chk("rst_a_ready", 32'(tl_d2h.a_ready), 32'd0);
        chk("rst_d_valid", 32'(tl_d2h.d_valid), 32'd0);
        chk("rst_axi_valids", 32'({wr_req.awvalid, wr_req.wvalid, rd_req.arvalid}), 32'd0);
        chk("rst_axi_readies", 32'({wr_req.bready, rd_req.rready}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_held_a_ready", 32'(tl_d2h.a_ready), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_a_ready", 32'(tl_d2h.a_ready), 32'd1);

        // Get 0x1000 against a zero-wait slave
        rd_rsp.arready = 1'b1;
        push_exp(AccessAckData, 1'b0, 32'hDEADBEEF, 8'h11, 2'd2);
        send_a(Get, 32'h0000_1000, 2'd2, 4'hF, 32'h0, 8'h11);
        chk("get_arvalid", 32'(rd_req.arvalid), 32'd1);
        chk("get_araddr", rd_req.araddr, 32'h0000_1000);
        chk("get_ar_fields", 32'({rd_req.arlen, rd_req.arsize, rd_req.arburst, rd_req.arid}),
            32'({8'd0, 3'd2, 2'b01, 4'd0}));
        chk("get_no_write_valid", 32'({wr_req.awvalid, wr_req.wvalid}), 32'd0);
        step();
        chk("get_arvalid_drop", 32'(rd_req.arvalid), 32'd0);
        chk("get_rready", 32'(rd_req.rready), 32'd1);
        rd_rsp.rvalid = 1'b1;
        rd_rsp.rdata  = 32'hDEADBEEF;
        rd_rsp.rresp  = OKAY;
        step();
        rd_rsp.rvalid  = 1'b0;
        rd_rsp.arready = 1'b0;
        expect_rsp("get_okay", 3);

        // PutPartialData, awready two cycles late, wready immediate
        wr_rsp.awready = 1'b0;
        wr_rsp.wready  = 1'b1;
        push_exp(AccessAck, 1'b0, 32'h0, 8'h22, 2'd1);
        send_a(PutPartialData, 32'h0000_2004, 2'd1, 4'h3, 32'h0000_1234, 8'h22);
        chk("pp_both_valid", 32'({wr_req.awvalid, wr_req.wvalid}), 32'b11);
        chk("pp_wstrb", 32'(wr_req.wstrb), 32'h3);
        chk("pp_wdata", wr_req.wdata, 32'h0000_1234);
        chk("pp_aw_fields", 32'({wr_req.awlen, wr_req.awsize, wr_req.awburst, wr_req.wlast}),
            32'({8'd0, 3'd1, 2'b01, 1'b1}));
        chk("pp_awaddr", wr_req.awaddr, 32'h0000_2004);
        step();
        chk("pp_wvalid_dropped", 32'({wr_req.awvalid, wr_req.wvalid}), 32'b10);
        step();
        chk("pp_awvalid_held", 32'({wr_req.awvalid, wr_req.wvalid}), 32'b10);
        wr_rsp.awready = 1'b1;
        step();
        wr_rsp.awready = 1'b0;
        chk("pp_awvalid_dropped", 32'(wr_req.awvalid), 32'd0);
        chk("pp_bready", 32'(wr_req.bready), 32'd1);
        wr_rsp.bvalid = 1'b1;
        wr_rsp.bresp  = OKAY;
        step();
        wr_rsp.bvalid = 1'b0;
        expect_rsp("pp_okay", 5);

        // PutFullData with SLVERR, zero-wait slave
        wr_rsp.awready = 1'b1;
        wr_rsp.wready  = 1'b1;
        push_exp(AccessAck, 1'b1, 32'h0, 8'h33, 2'd2);
        send_a(PutFullData, 32'h0000_3000, 2'd2, 4'hF, 32'hA5A5_5A5A, 8'h33);
        step();
        chk("pf_bready", 32'(wr_req.bready), 32'd1);
        wr_rsp.bvalid = 1'b1;
        wr_rsp.bresp  = SLVERR;
        step();
        wr_rsp.bvalid = 1'b0;
        expect_rsp("pf_slverr", 3);

        // Get with DECERR
        rd_rsp.arready = 1'b1;
        push_exp(AccessAckData, 1'b1, 32'h55AA_00FF, 8'h44, 2'd2);
        send_a(Get, 32'h0000_4000, 2'd2, 4'hF, 32'h0, 8'h44);
        step();
        rd_rsp.rvalid = 1'b1;
        rd_rsp.rdata  = 32'h55AA_00FF;
        rd_rsp.rresp  = DECERR;
        step();
        rd_rsp.rvalid  = 1'b0;
        rd_rsp.arready = 1'b0;
        expect_rsp("get_decerr", 3);

        // Unsupported opcode: error AccessAck, no AXI traffic
        push_exp(AccessAck, 1'b1, 32'h0, 8'h55, 2'd2);
        send_a(3'h5, 32'h0000_5000, 2'd2, 4'hF, 32'h0, 8'h55);
        chk("bad_op_no_axi_valid", 32'({wr_req.awvalid, wr_req.wvalid, rd_req.arvalid}), 32'd0);
        expect_rsp("bad_op", 1);

        // d_ready withheld for five cycles
        rd_rsp.arready = 1'b1;
        push_exp(AccessAckData, 1'b0, 32'hCAFE_F00D, 8'h66, 2'd2);
        send_a(Get, 32'h0000_6000, 2'd2, 4'hF, 32'h0, 8'h66);
        step();
        rd_rsp.rvalid = 1'b1;
        rd_rsp.rdata  = 32'hCAFE_F00D;
        rd_rsp.rresp  = OKAY;
        step();
        rd_rsp.rvalid  = 1'b0;
        rd_rsp.arready = 1'b0;
        rd_rsp.rdata   = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_d_valid", 32'(tl_d2h.d_valid), 32'd1);
            chk("stall_d_data", tl_d2h.d_data, 32'hCAFE_F00D);
            chk("stall_d_hdr", 32'({tl_d2h.d_opcode, tl_d2h.d_source, tl_d2h.d_error}),
                32'({AccessAckData, 8'h66, 1'b0}));
            chk("stall_a_ready", 32'(tl_d2h.a_ready), 32'd0);
            step();
        end
        expect_rsp("stall", 0);

`ifdef TLUL_AXI_BRIDGE_TIMEOUT_EN
        // Missing B response: timeout after 16 WR_RESP cycles, then drain the late beat
        wr_rsp.awready = 1'b1;
        wr_rsp.wready  = 1'b1;
        push_exp(AccessAck, 1'b1, 32'hFFFF_FFFF, 8'h77, 2'd2);
        send_a(PutFullData, 32'h0000_7000, 2'd2, 4'hF, 32'h1111_2222, 8'h77);
        expect_rsp("timeout", 18);
        for (int i = 0; i < 3; i++) begin
            chk("drain_a_ready", 32'(tl_d2h.a_ready), 32'd0);
            chk("drain_bready", 32'(wr_req.bready), 32'd1);
            step();
        end
        wr_rsp.bvalid = 1'b1;
        wr_rsp.bresp  = OKAY;
        step();
        wr_rsp.bvalid = 1'b0;
        chk("drain_done_a_ready", 32'(tl_d2h.a_ready), 32'd1);
        chk("drain_done_d_valid", 32'(tl_d2h.d_valid), 32'd0);
`endif

        // Reset while waiting in RD_RESP abandons the transaction
        rd_rsp.arready = 1'b1;
        send_a(Get, 32'h0000_8000, 2'd2, 4'hF, 32'h0, 8'h88);
        step();
        rd_rsp.arready = 1'b0;
        chk("abandon_rready", 32'(rd_req.rready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abandon_rst_rready", 32'(rd_req.rready), 32'd0);
        chk("abandon_rst_a_ready", 32'(tl_d2h.a_ready), 32'd0);
        chk("abandon_rst_d_valid", 32'(tl_d2h.d_valid), 32'd0);
        chk("abandon_rst_valids", 32'({wr_req.awvalid, wr_req.wvalid, rd_req.arvalid, wr_req.bready}), 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        chk("abandon_a_ready", 32'(tl_d2h.a_ready), 32'd1);
        rd_rsp.rvalid = 1'b1;
        rd_rsp.rdata  = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rd_rsp.rvalid = 1'b0;
            chk("abandon_no_response", 32'(tl_d2h.d_valid), 32'd0);
            step();
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlul_axi_bridge_ctrl.md
TLUL_AXI_BRIDGE_CTRL -- requirements
Module: tlul_axi_bridge_ctrl

Interface
REQ-001 SHALL have parameter AddrW, default 32, meaning AXI address width (must not exceed TL-UL a_address width).
REQ-002 SHALL have parameter TimeoutCycles, default 1024, meaning the B/R wait limit in clocks (used only under REQ-030).
REQ-003 SHALL have port clk_i, input, 1, sole clock.
REQ-004 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port tl_i, input, tlul_pkg::tl_h2d_t, TL-UL request from host.
REQ-006 SHALL have port tl_o, output, tlul_pkg::tl_d2h_t, TL-UL response to host.
REQ-007 SHALL have port axi_wr_req_o, output, axi_struct_pkg::axi_wr_req_t, AXI AW/W channels and bready.
REQ-008 SHALL have port axi_wr_rsp_i, input, axi_struct_pkg::axi_wr_rsp_t, AXI awready/wready and B channel.
REQ-009 SHALL have port axi_rd_req_o, output, axi_struct_pkg::axi_rd_req_t, AXI AR channel and rready.
REQ-010 SHALL have port axi_rd_rsp_i, input, axi_struct_pkg::axi_rd_rsp_t, AXI arready and R channel.

Function
REQ-011 SHALL implement FSM states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, TL_RSP (plus DRAIN under REQ-030); one TL transaction outstanding at most.
REQ-012 SHALL drive a_ready=1 only in IDLE; on a_valid&&a_ready, capture a_opcode, a_address, a_size, a_mask, a_data, a_source in the same edge.
REQ-013 SHALL go IDLE->WR_ADDR on PutFullData/PutPartialData, IDLE->RD_ADDR on Get, IDLE->TL_RSP with d_error=1, d_opcode=AccessAck for any other opcode (no AXI activity).
REQ-014 SHALL in WR_ADDR assert awvalid and wvalid together from the cycle after accept; each drops independently the cycle after its own handshake; move to WR_RESP when both done (same-cycle handshakes allowed).
REQ-015 SHALL drive single-beat fields: awlen/arlen=0, awburst/arburst=INCR, awsize/arsize=a_size, wlast=1, wstrb=a_mask, awid/arid=0, awaddr/araddr=a_address[AddrW-1:0].
REQ-016 SHALL in WR_RESP hold bready=1; on bvalid capture bresp, go TL_RSP.
REQ-017 SHALL in RD_ADDR hold arvalid=1 until arready, then RD_RESP with rready=1; on rvalid capture rdata and rresp, go TL_RSP; rlast ignored.
REQ-018 SHALL in TL_RSP drive d_valid=1, d_opcode=AccessAck (write/unsupported) or AccessAckData (read), d_source/d_size echoed, d_param=0, d_sink=0, d_user=TL_D_USER_DEFAULT; hold stable until d_ready, then IDLE.
REQ-019 SHALL set d_error=1 when captured resp is SLVERR or DECERR, else 0; d_data=rdata for reads, 0 for writes/unsupported.
REQ-020 SHALL keep all AXI valid outputs low outside their states; never drop a valid before its ready.
REQ-021 SHALL latency: write accept-to-d_valid = 3 cycles minimum (0-wait AXI slave), read likewise 3.

Reset
REQ-022 SHALL on rst_ni low asynchronously enter IDLE and force: a_ready=0 during reset then 1, d_valid=0, awvalid=wvalid=arvalid=0, bready=rready=0, captured registers 0, timeout counter 0.
REQ-023 SHALL treat reset mid-transaction as abandonment: no TL response is ever issued for it; AXI slave reset is the system's responsibility.

Configuration
REQ-030 SHALL, with TLUL_AXI_BRIDGE_TIMEOUT_EN defined, count cycles in WR_RESP/RD_RESP (counter cleared on state entry); at TimeoutCycles go TL_RSP with d_error=1, d_data=all-ones, then DRAIN instead of IDLE.
REQ-031 SHALL in DRAIN keep a_ready=0 and bready/rready=1 (matching abandoned channel) until the late beat is consumed, then IDLE.
REQ-032 SHALL, without the macro, contain no counter, no DRAIN state, and wait indefinitely in WR_RESP/RD_RESP.

Structure
REQ-040 SHALL place FSM state enum, AXI resp encodings (OKAY, EXOKAY, SLVERR, DECERR) and burst encoding INCR in tlul_axi_bridge_pkg; AXI structs stay in axi_struct_pkg.
REQ-041 SHALL be a single module; no sub-module required.

Verification
REQ-050 SHALL cover Get 0x1000, arready=1, rdata=0xDEADBEEF, rresp=OKAY -> d_valid 3 cycles after accept, AccessAckData, d_data=0xDEADBEEF, d_error=0.
REQ-051 SHALL cover PutPartialData mask=0x3, data=0x1234, awready 2 cycles late, wready immediate -> wvalid drops 1 cycle after accept-handshake, awvalid held, wstrb=0x3, AccessAck on bresp=OKAY.
REQ-052 SHALL cover bresp=SLVERR and rresp=DECERR -> d_error=1 in both.
REQ-053 SHALL cover opcode Intent/undefined 3'h5 -> AccessAck, d_error=1, no AXI valid asserted.
REQ-054 SHALL cover d_ready held 0 for 5 cycles -> d_* stable, a_ready=0 throughout.
REQ-055 SHALL cover (macro on, TimeoutCycles=16) no bvalid -> error response at cycle 16 of WR_RESP, a_ready=0 until late bvalid, then IDLE; also rst_ni pulse in RD_RESP -> all outputs to reset values, no response.
